// File: rtl/store_commit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : store_commit_arbiter_if
// Description : Retire, load-unit and Dcache signals of the store commit
//               arbiter. The slave modport is the arbiter's view and the
//               master modport is the view of the surrounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_commit_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  // retire -> store buffer
  logic             st_req;
  logic [XLEN-1:0]  st_addr;
  logic [63:0]      st_data;
  logic             sb_full;
  logic [CNT_W-1:0] sb_count;

  // load unit
  logic             ld_req;
  logic [XLEN-1:0]  ld_addr;
  logic             ld_grant;
  logic [63:0]      ld_data;

  // Dcache port
  logic             dc_req;
  logic [1:0]       dc_cmd;
  logic [XLEN-1:0]  dc_addr;
  logic [63:0]      dc_wdata;
  logic             dc_ready;
  logic [63:0]      dc_rdata;

  modport slave (
    input  st_req, st_addr, st_data, ld_req, ld_addr, dc_ready, dc_rdata,
    output sb_full, sb_count, ld_grant, ld_data, dc_req, dc_cmd, dc_addr, dc_wdata
  );

  modport master (
    output st_req, st_addr, st_data, ld_req, ld_addr, dc_ready, dc_rdata,
    input  sb_full, sb_count, ld_grant, ld_data, dc_req, dc_cmd, dc_addr, dc_wdata
  );
endinterface
`default_nettype wire

// File: rtl/store_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : store_commit_arbiter
// Description : Buffers retired store dwords in a FIFO, arbitrates the single
//               Dcache port between buffered stores and load-unit reads
//               (starvation and full-buffer drain control) and forwards
//               buffered dwords to matching loads.
// Revision    : 1.0 - initial release
// ============================================================================
module store_commit_arbiter #(
  parameter int XLEN         = 32,
  parameter int SB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  store_commit_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int TAG_W = XLEN - 3;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_LOAD  = 2'd1,
    OWN_STORE = 2'd2
  } owner_t;

  // Buffer storage keeps only the dword tag; stores are always dword aligned.
  logic [SB_DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [SB_DEPTH-1:0][63:0]      data_q, data_d;
  logic [PTR_W-1:0]               head_q, head_d;
  logic [PTR_W-1:0]               tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [STV_W-1:0]               starve_q, starve_d;
  state_t                         state_q, state_d;
  owner_t                         owner_q, owner_d;

  logic        full;
  logic        enq;
  logic        deq;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic        load_cand;
  logic        store_cand;
  owner_t      owner_cur;
  logic        load_done;
  logic        store_done;
  logic        unused_addr_lsbs;

  // Full comes from the registered count only, so a same-cycle dequeue never frees a slot early.
  assign full       = (count_q == CNT_W'(SB_DEPTH));
  assign enq        = bus.st_req && !full;
  assign load_done  = (owner_cur == OWN_LOAD) && bus.dc_ready;
  assign store_done = (owner_cur == OWN_STORE) && bus.dc_ready;
  assign deq        = store_done;

  assign bus.sb_full  = full;
  assign bus.sb_count = count_q;

  // Sub-dword address bits never reach the cache or the forwarding compare.
  assign unused_addr_lsbs = ^{bus.st_addr[2:0], bus.ld_addr[2:0]};

  // Forwarding: youngest valid entry with a matching dword tag wins. Registered
  // entries only, so a store enqueued this cycle is not seen. Disabled while a
  // Dcache load already owns the port so the outstanding load completes alone.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (bus.ld_req && (owner_q != OWN_LOAD) && (CNT_W'(i) < count_q) &&
          (tag_q[head_q + PTR_W'(i)] == bus.ld_addr[XLEN-1:3])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PTR_W'(i)];
      end
    end
  end

  // Port owner: a locked owner keeps the port, otherwise pick by drain state.
  always_comb begin
    load_cand  = bus.ld_req && !fwd_hit;
    store_cand = (count_q != '0);
    owner_cur  = owner_q;
    if (owner_q == OWN_NONE) begin
      if (state_q == ST_DRAIN) begin
        if (store_cand)     owner_cur = OWN_STORE;
        else if (load_cand) owner_cur = OWN_LOAD;
        else                owner_cur = OWN_NONE;
      end else begin
        if (load_cand)       owner_cur = OWN_LOAD;
        else if (store_cand) owner_cur = OWN_STORE;
        else                 owner_cur = OWN_NONE;
      end
    end
  end

  // Dcache request payload; held stable while locked because the head entry and
  // the load address cannot change until dc_ready.
  always_comb begin
    bus.dc_req   = 1'b0;
    bus.dc_cmd   = BUS_NONE;
    bus.dc_addr  = '0;
    bus.dc_wdata = '0;
    case (owner_cur)
      OWN_LOAD: begin
        bus.dc_req  = 1'b1;
        bus.dc_cmd  = BUS_LOAD;
        bus.dc_addr = {bus.ld_addr[XLEN-1:3], 3'b000};
      end
      OWN_STORE: begin
        bus.dc_req   = 1'b1;
        bus.dc_cmd   = BUS_STORE;
        bus.dc_addr  = {tag_q[head_q], 3'b000};
        bus.dc_wdata = data_q[head_q];
      end
      default: begin
      end
    endcase
  end

  // Load return: forwarded dword or Dcache data on completion.
  always_comb begin
    bus.ld_grant = 1'b0;
    bus.ld_data  = '0;
    if (fwd_hit) begin
      bus.ld_grant = 1'b1;
      bus.ld_data  = fwd_data;
    end else if (load_done) begin
      bus.ld_grant = 1'b1;
      bus.ld_data  = bus.dc_rdata;
    end
  end

  // FIFO next state: write at tail, retire head on store completion.
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (enq) begin
      tag_d[tail_q]  = bus.st_addr[XLEN-1:3];
      data_d[tail_q] = bus.st_data;
      tail_d         = tail_q + 1'b1;
    end
    if (deq) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  // Starvation counter, drain FSM and owner lock next state. Drain entry looks at
  // the next-cycle count/starve values so it takes effect the cycle after the
  // limit is reached.
  always_comb begin
    starve_d = starve_q;
    if (store_done || (count_q == '0)) begin
      starve_d = '0;
    end else if (load_done && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if ((count_d == CNT_W'(SB_DEPTH)) || (starve_d == STV_W'(STARVE_LIMIT))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((store_done && (count_d < CNT_W'(SB_DEPTH / 2))) || (count_q == '0)) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    owner_d = OWN_NONE;
    if ((owner_cur != OWN_NONE) && !bus.dc_ready) begin
      owner_d = owner_cur;
    end
  end

  // State registers; reset abandons any outstanding request and buffered stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q    <= '0;
      data_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      state_q  <= ST_NORMAL;
      owner_q  <= OWN_NONE;
    end else begin
      tag_q    <= tag_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      state_q  <= state_d;
      owner_q  <= owner_d;
    end
  end

  // Retire must respect sb_full; a push while full is dropped.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(bus.st_req && full));

endmodule
`default_nettype wire

// File: tb/tb_store_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_commit_arbiter
// Description : Directed scenarios plus randomized traffic checked against a
//               queue-based reference model of the store commit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_commit_arbiter;

  localparam int XLEN         = 32;
  localparam int SB_DEPTH     = 4;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  store_commit_arbiter_if #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) bus ();

  store_commit_arbiter #(
    .XLEN(XLEN), .SB_DEPTH(SB_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_owner;   // 0 none, 1 load, 2 store
  bit          m_drain;
  int          m_starve;
  int          e_cur;
  bit          e_fwd;
  bit          e_full;
  bit          e_grant;
  logic [63:0] e_ldata;
  logic [31:0] e_addr;
  logic [63:0] e_wdata;

  function automatic void model_reset();
    mq.delete();
    m_owner  = 0;
    m_drain  = 0;
    m_starve = 0;
  endfunction

  function automatic void model_predict();
    bit lc;
    bit sc;
    e_full  = (mq.size() == SB_DEPTH);
    e_fwd   = 0;
    e_ldata = '0;
    if (bus.ld_req && m_owner != 1)
      foreach (mq[i])
        if (mq[i].a[31:3] == bus.ld_addr[31:3]) begin
          e_fwd   = 1;
          e_ldata = mq[i].d;
        end
    lc = bus.ld_req && !e_fwd;
    sc = (mq.size() > 0);
    if (m_owner != 0)  e_cur = m_owner;
    else if (m_drain)  e_cur = sc ? 2 : (lc ? 1 : 0);
    else               e_cur = lc ? 1 : (sc ? 2 : 0);
    e_addr  = (e_cur == 1) ? {bus.ld_addr[31:3], 3'b000} : (e_cur == 2) ? mq[0].a : 32'h0;
    e_wdata = (e_cur == 2) ? mq[0].d : 64'h0;
    e_grant = e_fwd || (e_cur == 1 && bus.dc_ready);
    if (e_cur == 1 && bus.dc_ready) e_ldata = bus.dc_rdata;
  endfunction

  function automatic void model_commit();
    int prev  = mq.size();
    bit sdone = (e_cur == 2) && bus.dc_ready;
    bit ldone = (e_cur == 1) && bus.dc_ready;
    if (sdone) mq.delete(0);
    if (bus.st_req && !e_full) mq.push_back('{a: bus.st_addr, d: bus.st_data});
    if (sdone || prev == 0)                   m_starve = 0;
    else if (ldone && m_starve < STARVE_LIMIT) m_starve++;
    if (!m_drain) m_drain = (mq.size() == SB_DEPTH) || (m_starve == STARVE_LIMIT);
    else if ((sdone && mq.size() < SB_DEPTH / 2) || prev == 0) m_drain = 0;
    m_owner = (e_cur != 0 && !bus.dc_ready) ? e_cur : 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.st_req   = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_req   = 1'b0;
    bus.ld_addr  = '0;
    bus.dc_ready = 1'b0;
    bus.dc_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.sb_count !== 3'd0 || bus.sb_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_count: got count=%0d full=%0b expected 0/0", bus.sb_count, bus.sb_full);
    end
    n_tests++;
    if (bus.dc_req !== 1'b0 || bus.dc_cmd !== 2'd0) begin
      n_fail++; $display("FAIL reset_dc: got req=%0b cmd=%0d expected 0/0", bus.dc_req, bus.dc_cmd);
    end
    n_tests++;
    if (bus.ld_grant !== 1'b0 || bus.ld_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_ld: got grant=%0b data=%h expected 0/0", bus.ld_grant, bus.ld_data);
    end
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_store_issue();
    do_reset();
    bus.dc_ready = 1'b1;
    bus.st_req = 1'b1; bus.st_addr = 32'h1000; bus.st_data = 64'hAA;
    #1;
    n_tests++;
    if (bus.dc_req !== 1'b0 || bus.sb_count !== 3'd0) begin
      n_fail++; $display("FAIL st_enq_cycle: got req=%0b count=%0d expected 0/0", bus.dc_req, bus.sb_count);
    end
    cyc();
    bus.st_req = 1'b0;
    #1;
    n_tests++;
    if (bus.dc_cmd !== 2'd2 || bus.dc_addr !== 32'h1000 || bus.dc_wdata !== 64'hAA || bus.sb_count !== 3'd1) begin
      n_fail++; $display("FAIL st_issue: got cmd=%0d addr=%h wdata=%h count=%0d expected 2/1000/aa/1",
                         bus.dc_cmd, bus.dc_addr, bus.dc_wdata, bus.sb_count);
    end
    cyc();
    #1;
    n_tests++;
    if (bus.sb_count !== 3'd0 || bus.dc_req !== 1'b0) begin
      n_fail++; $display("FAIL st_done: got count=%0d req=%0b expected 0/0", bus.sb_count, bus.dc_req);
    end
  endtask

  task automatic test_full_drain();
    logic [31:0] exp_a;
    do_reset();
    for (int i = 0; i < SB_DEPTH; i++) begin
      bus.st_req = 1'b1; bus.st_addr = 32'h3000 + 32'(i * 8); bus.st_data = 64'(i + 1);
      cyc();
    end
    bus.st_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h5000; bus.dc_rdata = 64'h5A5A;
    #1;
    n_tests++;
    if (bus.sb_full !== 1'b1 || bus.sb_count !== 3'd4 || bus.dc_cmd !== 2'd2 || bus.dc_addr !== 32'h3000) begin
      n_fail++; $display("FAIL full_lock: got full=%0b count=%0d cmd=%0d addr=%h expected 1/4/2/3000",
                         bus.sb_full, bus.sb_count, bus.dc_cmd, bus.dc_addr);
    end
    bus.dc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_a = 32'h3000 + 32'(i * 8);
      n_tests++;
      if (bus.dc_cmd !== 2'd2 || bus.dc_addr !== exp_a || bus.ld_grant !== 1'b0) begin
        n_fail++; $display("FAIL drain_store%0d: got cmd=%0d addr=%h grant=%0b expected 2/%h/0",
                           i, bus.dc_cmd, bus.dc_addr, bus.ld_grant, exp_a);
      end
      cyc();
    end
    #1;
    n_tests++;
    if (bus.dc_cmd !== 2'd1 || bus.sb_count !== 3'd1 || bus.ld_grant !== 1'b1 || bus.ld_data !== 64'h5A5A) begin
      n_fail++; $display("FAIL drain_exit_load: got cmd=%0d count=%0d grant=%0b data=%h expected 1/1/1/5a5a",
                         bus.dc_cmd, bus.sb_count, bus.ld_grant, bus.ld_data);
    end
    cyc();
    bus.ld_req = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    bus.st_req = 1'b1; bus.st_addr = 32'h2000; bus.st_data = 64'h55;
    cyc();
    bus.st_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h2004;
    #1;
    n_tests++;
    if (bus.ld_grant !== 1'b1 || bus.ld_data !== 64'h55 || bus.dc_cmd !== 2'd2) begin
      n_fail++; $display("FAIL fwd_single: got grant=%0b data=%h cmd=%0d expected 1/55/2",
                         bus.ld_grant, bus.ld_data, bus.dc_cmd);
    end
    cyc();
    bus.ld_req = 1'b0;
    bus.st_req = 1'b1; bus.st_data = 64'h11;
    cyc();
    bus.st_data = 64'h22;
    bus.ld_req  = 1'b1; bus.ld_addr = 32'h2000;
    #1;
    n_tests++;
    if (bus.ld_data !== 64'h11) begin
      n_fail++; $display("FAIL fwd_no_same_cycle: got %h expected 11", bus.ld_data);
    end
    cyc();
    bus.st_req = 1'b0;
    #1;
    n_tests++;
    if (bus.ld_grant !== 1'b1 || bus.ld_data !== 64'h22) begin
      n_fail++; $display("FAIL fwd_youngest: got grant=%0b data=%h expected 1/22", bus.ld_grant, bus.ld_data);
    end
    bus.ld_addr = 32'h2008;
    #1;
    n_tests++;
    if (bus.ld_grant !== 1'b0 || bus.dc_cmd !== 2'd2) begin
      n_fail++; $display("FAIL fwd_miss: got grant=%0b cmd=%0d expected 0/2", bus.ld_grant, bus.dc_cmd);
    end
    cyc();
    bus.ld_req = 1'b0;
  endtask

  task automatic test_starvation();
    do_reset();
    bus.dc_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bus.ld_req = 1'b0;
      bus.st_req = 1'b1; bus.st_addr = 32'h4000; bus.st_data = 64'h77 + 64'(r);
      cyc();
      bus.st_req = 1'b0;
      bus.ld_req = 1'b1; bus.ld_addr = 32'h6000;
      for (int k = 0; k < STARVE_LIMIT; k++) begin
        bus.dc_rdata = 64'h100 * 64'(r + 1) + 64'(k);
        #1;
        n_tests++;
        if (bus.dc_cmd !== 2'd1 || bus.ld_grant !== 1'b1 || bus.ld_data !== bus.dc_rdata) begin
          n_fail++; $display("FAIL starve_load r%0d k%0d: got cmd=%0d grant=%0b data=%h expected 1/1/%h",
                             r, k, bus.dc_cmd, bus.ld_grant, bus.ld_data, bus.dc_rdata);
        end
        cyc();
      end
      #1;
      n_tests++;
      if (bus.dc_cmd !== 2'd2 || bus.dc_addr !== 32'h4000 || bus.ld_grant !== 1'b0) begin
        n_fail++; $display("FAIL starve_store r%0d: got cmd=%0d addr=%h grant=%0b expected 2/4000/0",
                           r, bus.dc_cmd, bus.dc_addr, bus.ld_grant);
      end
      cyc();
      #1;
      n_tests++;
      if (bus.dc_cmd !== 2'd1 || bus.sb_count !== 3'd0) begin
        n_fail++; $display("FAIL starve_after r%0d: got cmd=%0d count=%0d expected 1/0", r, bus.dc_cmd, bus.sb_count);
      end
      cyc();
    end
    bus.ld_req = 1'b0;
  endtask

  task automatic test_load_stall();
    do_reset();
    bus.ld_req = 1'b1; bus.ld_addr = 32'h7000; bus.dc_rdata = 64'hDEAD;
    for (int c = 0; c < 3; c++) begin
      bus.st_req = (c == 1); bus.st_addr = 32'h7100; bus.st_data = 64'h99;
      #1;
      n_tests++;
      if (bus.dc_cmd !== 2'd1 || bus.dc_addr !== 32'h7000 || bus.ld_grant !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold c%0d: got cmd=%0d addr=%h grant=%0b expected 1/7000/0",
                           c, bus.dc_cmd, bus.dc_addr, bus.ld_grant);
      end
      cyc();
    end
    bus.st_req = 1'b0;
    bus.dc_ready = 1'b1; bus.dc_rdata = 64'hBEEF;
    #1;
    n_tests++;
    if (bus.ld_grant !== 1'b1 || bus.ld_data !== 64'hBEEF || bus.sb_count !== 3'd1) begin
      n_fail++; $display("FAIL stall_done: got grant=%0b data=%h count=%0d expected 1/beef/1",
                         bus.ld_grant, bus.ld_data, bus.sb_count);
    end
    cyc();
    bus.ld_req = 1'b0;
    #1;
    n_tests++;
    if (bus.dc_cmd !== 2'd2 || bus.dc_addr !== 32'h7100 || bus.dc_wdata !== 64'h99) begin
      n_fail++; $display("FAIL stall_store: got cmd=%0d addr=%h wdata=%h expected 2/7100/99",
                         bus.dc_cmd, bus.dc_addr, bus.dc_wdata);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.st_req = 1'b1; bus.st_addr = 32'h8000 + 32'(i * 8); bus.st_data = 64'(i);
      cyc();
    end
    bus.st_req = 1'b0;
    #1;
    n_tests++;
    if (bus.sb_count !== 3'd3 || bus.dc_cmd !== 2'd2) begin
      n_fail++; $display("FAIL rstmid_pre: got count=%0d cmd=%0d expected 3/2", bus.sb_count, bus.dc_cmd);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.dc_req !== 1'b0 || bus.sb_count !== 3'd0 || bus.sb_full !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got req=%0b count=%0d full=%0b expected 0/0/0",
                         bus.dc_req, bus.sb_count, bus.sb_full);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.st_req = 1'b1; bus.st_addr = 32'h9000; bus.st_data = 64'h1;
    cyc();
    bus.st_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 32'hA000;
    #1;
    n_tests++;
    if (bus.dc_cmd !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_normal: got cmd=%0d expected 1", bus.dc_cmd);
    end
    cyc();
    bus.ld_req = 1'b0;
  endtask

  task automatic test_random();
    bit ld_hold;
    logic [167:0] got;
    logic [167:0] exp;
    do_reset();
    ld_hold = 0;
    for (int c = 0; c < 600; c++) begin
      bus.dc_ready = ($urandom_range(0, 99) < 55);
      bus.dc_rdata = {$urandom, $urandom};
      bus.st_req   = (mq.size() < SB_DEPTH) && ($urandom_range(0, 99) < 40);
      bus.st_addr  = 32'h2000 + 32'($urandom_range(0, 5) * 8);
      bus.st_data  = {$urandom, $urandom};
      if (!ld_hold) begin
        bus.ld_req  = ($urandom_range(0, 99) < 50);
        bus.ld_addr = 32'h2000 + 32'($urandom_range(0, 5) * 8) + 32'($urandom_range(0, 7));
      end
      #1;
      model_predict();
      got = {bus.sb_full, bus.sb_count, bus.ld_grant, bus.ld_data, bus.dc_req, bus.dc_cmd, bus.dc_addr, bus.dc_wdata};
      exp = {e_full, 3'(mq.size()), e_grant, e_ldata, (e_cur != 0), 2'(e_cur), e_addr, e_wdata};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random c%0d: got %h expected %h", c, got, exp);
      end
      @(posedge clk);
      model_commit();
      ld_hold = bus.ld_req && !e_grant;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_store_issue();
    test_full_drain();
    test_forward();
    test_starvation();
    test_load_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
